sync_fifo_flags: RTL



---
 rtl/sync_fifo_flags.sv | 65 ++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FWFT FIFO with level, almost thresholds, sticky errors and flush.
module sync_fifo_flags #(
  parameter int DATA_WIDTH         = 4,
  parameter int ADDRESS_WIDTH      = 5,
  parameter int ALMOST_FULL_LEVEL  = 2**ADDRESS_WIDTH-4,
  parameter int ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     clear_errors,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     write_increment,
  input  logic                     read_increment,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] AF_LVL = ALMOST_FULL_LEVEL[AW:0];
  localparam logic [AW:0] AE_LVL = ALMOST_EMPTY_LEVEL[AW:0];
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic read_accept, write_accept;
  assign level        = wr_ptr_q - rd_ptr_q;
  assign empty        = wr_ptr_q == rd_ptr_q;
  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign almost_empty = level <= AE_LVL;
  assign almost_full  = level >= AF_LVL;
  assign read_data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  // a pop frees the slot a same-cycle push at full needs; a push never rescues a pop at empty
  assign read_accept  = read_increment & ~empty;
  assign write_accept = write_increment & (~full | read_accept);
  always_comb begin
    wr_ptr_d    = flush ? '0 : wr_ptr_q + {{AW{1'b0}}, write_accept};
    rd_ptr_d    = flush ? '0 : rd_ptr_q + {{AW{1'b0}}, read_accept};
    overflow_d  = (~flush & write_increment & ~write_accept) | (overflow_q & ~clear_errors);
    underflow_d = (~flush & read_increment & ~read_accept) | (underflow_q & ~clear_errors);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (write_accept && !flush) mem_q[wr_ptr_q[AW-1:0]] <= write_data;
  end
endmodule
